// File: rtl/word_byte_serializer.sv
// word_byte_serializer: holds a 32-bit word and steps a 4:1 byte selector through its lanes
module word_byte_serializer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic [31:0] word_o,
   output logic [1:0]  sel_o,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        byte_last,
   output logic        busy
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t      state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        beat, accept;
   assign byte_valid = state_q == SEND;
   assign busy       = byte_valid;
   assign byte_last  = byte_valid && cnt_q == 2'd3;
   assign beat       = byte_valid && byte_ready;
   assign word_ready = rst_n && (state_q == IDLE || (beat && cnt_q == 2'd3));
   assign accept     = word_valid && word_ready;
   assign word_o     = word_q;
   assign sel_o      = MSB_FIRST ? 2'd3 - cnt_q : cnt_q;
   // next state: load on accept, advance beat index on each byte beat, drop to IDLE after the last lane
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      if (accept) begin
         word_d  = word_in;
         cnt_d   = 2'd0;
         state_d = SEND;
      end else if (beat) begin
         cnt_d   = cnt_q == 2'd3 ? 2'd0 : cnt_q + 2'd1;
         state_d = cnt_q == 2'd3 ? IDLE : SEND;
      end
   end
   // state registers, cleared immediately on reset so a partial word is discarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= 32'd0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: table vectors, directed corner cases and random traffic against a lane-queue model
module tb_word_byte_serializer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] word_in = 32'd0;
   logic        word_valid = 1'b0;
   logic        byte_ready = 1'b0;
   logic        wr0, bv0, bl0, bz0, wr1, bv1, bl1, bz1;
   logic [31:0] wo0, wo1;
   logic [1:0]  sel0, sel1;
   int          pass_cnt = 0;
   int          tot = 0;
   int          q0[$];
   int          q1[$];
   logic [31:0] mw = 32'd0;

   word_byte_serializer #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid), .word_ready(wr0),
      .word_o(wo0), .sel_o(sel0), .byte_valid(bv0), .byte_ready(byte_ready), .byte_last(bl0), .busy(bz0));
   word_byte_serializer #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid), .word_ready(wr1),
      .word_o(wo1), .sel_o(sel1), .byte_valid(bv1), .byte_ready(byte_ready), .byte_last(bl1), .busy(bz1));

   always #5 clk = ~clk;

   typedef struct {
      logic        wv;
      logic [31:0] w;
      logic        br;
      logic        ev;
      logic [1:0]  es;
      logic [7:0]  eb;
      logic        el;
      logic        er;
   } vec_t;
   vec_t tv[16];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tot++;
      if (a === e) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
   endtask

   function automatic logic [7:0] lane(input logic [31:0] w, input int l);
      return w[l*8 +: 8];
   endfunction

   // compares both DUTs against the model, then advances the model across the coming edge
   task automatic model_check();
      bit v = q0.size() != 0;
      bit rdy = q0.size() == 0 || (byte_ready && q0.size() == 1);
      chk("valid0", bv0, v);
      chk("valid1", bv1, v);
      chk("busy0", bz0, v);
      chk("busy1", bz1, v);
      chk("last0", bl0, q0.size() == 1);
      chk("last1", bl1, q1.size() == 1);
      chk("ready0", wr0, rdy);
      chk("ready1", wr1, rdy);
      chk("word0", wo0, mw);
      chk("word1", wo1, mw);
      chk("sel0", sel0, v ? q0[0] : 0);
      chk("sel1", sel1, v ? q1[0] : 3);
      if (v) begin
         chk("byte0", lane(wo0, int'(sel0)), lane(mw, q0[0]));
         chk("byte1", lane(wo1, int'(sel1)), lane(mw, q1[0]));
      end
      if (v && byte_ready) begin
         void'(q0.pop_front());
         void'(q1.pop_front());
      end
      if (word_valid && rdy) begin
         mw = word_in;
         q0 = '{0, 1, 2, 3};
         q1 = '{3, 2, 1, 0};
      end
   endtask

   task automatic step(input logic wv, input logic [31:0] w, input logic br);
      @(negedge clk);
      word_valid = wv;
      word_in    = w;
      byte_ready = br;
      #1;
      model_check();
   endtask

   initial begin
      tv[0]  = '{1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1};
      tv[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd0, 8'hAA, 1'b0, 1'b0};
      tv[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd1, 8'hBB, 1'b0, 1'b0};
      tv[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd2, 8'hCC, 1'b0, 1'b0};
      tv[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd3, 8'hDD, 1'b1, 1'b1};
      tv[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1};
      tv[6]  = '{1'b1, 32'h44332211, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1};
      tv[7]  = '{1'b1, 32'h44332211, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0};
      tv[8]  = '{1'b1, 32'h44332211, 1'b1, 1'b1, 2'd1, 8'h22, 1'b0, 1'b0};
      tv[9]  = '{1'b1, 32'h44332211, 1'b1, 1'b1, 2'd2, 8'h33, 1'b0, 1'b0};
      tv[10] = '{1'b1, 32'h88776655, 1'b1, 1'b1, 2'd3, 8'h44, 1'b1, 1'b1};
      tv[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd0, 8'h55, 1'b0, 1'b0};
      tv[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd1, 8'h66, 1'b0, 1'b0};
      tv[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd2, 8'h77, 1'b0, 1'b0};
      tv[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 2'd3, 8'h88, 1'b1, 1'b1};
      tv[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1};

      @(posedge clk);
      #1;
      chk("rst_ready0", wr0, 0);
      chk("rst_valid0", bv0, 0);
      chk("rst_last0", bl0, 0);
      chk("rst_busy0", bz0, 0);
      chk("rst_word0", wo0, 0);
      chk("rst_sel0", sel0, 0);
      chk("rst_sel1", sel1, 3);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_ready0", wr0, 1);

      for (int i = 0; i < 16; i++) begin
         step(tv[i].wv, tv[i].w, tv[i].br);
         chk($sformatf("tv%0d_valid", i), bv0, tv[i].ev);
         chk($sformatf("tv%0d_ready", i), wr0, tv[i].er);
         chk($sformatf("tv%0d_last", i), bl0, tv[i].el);
         chk($sformatf("tv%0d_sel", i), sel0, tv[i].es);
         if (tv[i].ev) chk($sformatf("tv%0d_byte", i), lane(wo0, int'(sel0)), tv[i].eb);
      end

      step(1'b1, 32'hDDCCBBAA, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h0, 1'b0);
         chk("bp_sel", sel0, 2);
         chk("bp_word", wo0, 32'hDDCCBBAA);
         chk("bp_valid", bv0, 1);
      end
      step(1'b0, 32'h0, 1'b1);
      chk("bp_cc", lane(wo0, int'(sel0)), 8'hCC);
      step(1'b0, 32'h0, 1'b1);
      chk("bp_dd", lane(wo0, int'(sel0)), 8'hDD);
      step(1'b0, 32'h0, 1'b1);

      step(1'b1, 32'hDDCCBBAA, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'h12345678, 1'b1);
      chk("stab_bb", lane(wo0, int'(sel0)), 8'hBB);
      step(1'b1, 32'h12345678, 1'b1);
      chk("stab_cc", lane(wo0, int'(sel0)), 8'hCC);
      step(1'b1, 32'h12345678, 1'b1);
      chk("stab_dd_ready", wr0, 1);
      chk("stab_dd_msb", lane(wo1, int'(sel1)), 8'hAA);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);

      step(1'b1, 32'hDDCCBBAA, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bv0, 0);
      chk("mid_rst_sel0", sel0, 0);
      chk("mid_rst_sel1", sel1, 3);
      chk("mid_rst_last", bl0, 0);
      chk("mid_rst_ready", wr0, 0);
      q0 = {};
      q1 = {};
      mw = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'h0000EE00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1);
         chk("post_rst_sel", sel0, i);
      end

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);

      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end
endmodule
